// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_e : FSM state encoding (IDLE, RUN, DONE)
//   MULT_N  : default operand/result width
//   clog2() : ceil(log2(value)), used to size the iteration counter
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest r such that 2**r >= value; the counter must hold 0..N.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add unsigned multiplier: one multiplier bit per clock.
// Returns the low N bits of A*B and an overflow flag (upper N bits non-zero).
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, only honoured while idle
//   A      in   N-bit multiplicand, captured on the accepted start
//   B      in   N-bit multiplier, captured on the accepted start
//   busy   out  high from the cycle after start is accepted until done
//   done   out  one-cycle pulse, Res/ovf valid from this cycle
//   Res    out  low N bits of A*B, held until the next result
//   ovf    out  A*B >= 2**N
//
// Build option:
//   MULT_EARLY_TERM_EN  when defined, the run stops as soon as the remaining
//                       multiplier bits are all zero; results are unchanged.
// ---------------------------------------------------------------------------
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Res,
  output logic         ovf
);

  localparam int CW = clog2(N + 1);

  state_e           state_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   mcand_q;
  logic [N-1:0]     mplier_q;
  logic [CW-1:0]    cnt_q;

  logic [2*N-1:0]   accSum_d;
  logic [N-1:0]     mplier_d;
  logic             lastIter;

  // The accumulator never exceeds the 2N-bit product, so the add cannot carry out.
  assign accSum_d = acc_q + mcand_q;
  assign mplier_d = mplier_q >> 1;

  // Decide whether the current RUN cycle is the final iteration.
`ifdef MULT_EARLY_TERM_EN
  assign lastIter = (cnt_q == CW'(N - 1)) || (mplier_d == '0);
`else
  assign lastIter = (cnt_q == CW'(N - 1));
`endif

  // Single FSM process: datapath registers and all outputs are registered here.
  // Res/ovf are updated only on the DONE cycle, so they stay stable while a
  // later operation is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Res      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, A};
            mplier_q <= B;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (mplier_q[0]) acc_q <= accSum_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (lastIter) state_q <= DONE;
        end
        DONE: begin
          Res     <= acc_q[N-1:0];
          ovf     <= |acc_q[2*N-1:N];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Scoreboard bench for seq_multiplier (N=32). Stimulus pushes the expected
// result and done cycle into a queue; a monitor pops and compares on done.
// Follows MULT_EARLY_TERM_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Res;
  logic         ovf;

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    int           doneCycle;
    int           lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  // Hand-computed products: {A, B, low 32 bits, overflow}.
  localparam vec_t VECS [11] = '{
    '{32'd100,       32'd10,        32'd1000,      1'b0},
    '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1},
    '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1},
    '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1},
    '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0},
    '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0},
    '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0},
    '{32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0},
    '{32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1},
    '{32'd3,         32'd5,         32'd15,        1'b0}
  };

  exp_t sbQ[$];
  int   cycle;
  int   busyCnt;
  int   doneCount;
  int   checkCount;
  int   passCount;
  logic [N-1:0] lastRes;
  logic         lastOvf;

  seq_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Res   (Res),
    .ovf   (ovf)
  );

  // Free-running clock and cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  // One comparison: counts it, reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount = checkCount + 1;
    if (actual === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Cycles from the accepted start edge to the edge that makes done visible.
  function automatic int expLat(input logic [N-1:0] b);
    int runLen;
`ifdef MULT_EARLY_TERM_EN
    runLen = 1;
    for (int i = 0; i < N; i++) if (b[i]) runLen = i + 1;
`else
    runLen = N;
`endif
    return runLen + 1;
  endfunction

  // Issue one start; when tracked, push its expected response to the scoreboard.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] expRes, input logic expOvf,
                               input bit track);
    exp_t e;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    if (track) begin
      e.res       = expRes;
      e.ovf       = expOvf;
      e.lat       = expLat(b);
      e.doneCycle = cycle + 1 + e.lat;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    checkOutput("busyAfterStart", 64'(busy), 64'd1);
  endtask

  // Bounded wait for the next done pulse seen by the monitor.
  task automatic waitForDone();
    int prev;
    bit seen;
    prev = doneCount;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (doneCount > prev) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
  endtask

  // Monitor: on every done pulse pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busyCnt = 0;
    end else begin
      if (busy) busyCnt = busyCnt + 1;
      if (done) begin
        doneCount = doneCount + 1;
        checkOutput("expectationPending", 64'(sbQ.size() > 0), 64'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkOutput("Res", 64'(Res), 64'(e.res));
          checkOutput("ovf", 64'(ovf), 64'(e.ovf));
          checkOutput("doneCycle", 64'(cycle), 64'(e.doneCycle));
          checkOutput("busyCycles", 64'(busyCnt), 64'(e.lat));
          checkOutput("busyLowAtDone", 64'(busy), 64'd0);
          lastRes = e.res;
          lastOvf = e.ovf;
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    logic [63:0] prod;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    checkCount = 0;
    passCount  = 0;
    doneCount  = 0;
    busyCnt    = 0;
    lastRes    = '0;
    lastOvf    = 1'b0;
    start      = 1'b0;
    A          = '0;
    B          = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    checkOutput("resetRes", 64'(Res), 64'd0);
    checkOutput("resetOvf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, issued back-to-back; Res must hold the previous result mid-run.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(VECS[i].a, VECS[i].b, VECS[i].res, VECS[i].ovf, 1'b1);
      checkOutput("resHeldDuringRun", 64'(Res), 64'(lastRes));
      checkOutput("ovfHeldDuringRun", 64'(ovf), 64'(lastOvf));
      waitForDone();
    end

    // A second start while busy must be ignored: one done, Res = 16*3.
    applyStimulus(32'd16, 32'd3, 32'd48, 1'b0, 1'b1);
    @(negedge clk);
    A     = 32'd7;
    B     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitForDone();
    repeat (40) @(negedge clk);
    checkOutput("resAfterIgnoredStart", 64'(Res), 64'd48);

    // Abort a run with reset; nothing may complete and outputs clear.
    applyStimulus(32'h0000_DEAD, 32'h0000_BEEF, '0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    checkOutput("abortRes", 64'(Res), 64'd0);
    checkOutput("abortOvf", 64'(ovf), 64'd0);
    lastRes = '0;
    lastOvf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("noDoneAfterAbort", 64'(done), 64'd0);
    applyStimulus(32'd255, 32'd5, 32'd1275, 1'b0, 1'b1);
    waitForDone();

    // A few random operands against the full-width product.
    for (int i = 0; i < 4; i++) begin
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(0, 31);
      prod = {32'd0, ra} * {32'd0, rb};
      applyStimulus(ra, rb, prod[31:0], |prod[63:32], 1'b1);
      waitForDone();
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", 64'(sbQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
